// File: rtl/fc_result_streamer.sv
// Streams the FC layer result RAM out over valid/ready, with optional on-the-fly arg-max.
// Optional feature: define FC_ARGMAX_EN to build the arg-max tracker.
module fc_result_streamer #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned OUTPUT_MAP = 84,
   parameter int unsigned ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [ADDR_WIDTH-1:0] m_index,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] max_index,
   output logic [DATA_WIDTH-1:0] max_value
);

   localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [ADDR_WIDTH-1:0] idx;
      logic                  last;
   } word_t;

   state_t                 state_q;
   logic                   start_q;
   word_t                  out_q, out_n;
   logic                   out_vld_q, out_vld_n;
   word_t                  fifo_q [2];
   word_t                  fifo_n [2];
   logic [1:0]             fcnt_q, fcnt_n;
   logic                   pend_q;
   logic [ADDR_WIDTH-1:0]  pend_idx_q;
   logic [CNT_WIDTH-1:0]   next_addr_q;

   logic                   start_rise_c;
   logic                   xfer_c;
   logic                   slot_free_c;
   logic                   stream_next_c;
   logic                   issue_c;
   word_t                  in_word_c;

   assign start_rise_c  = start && !start_q;
   assign xfer_c        = (state_q == STREAM) && out_vld_q && m_ready;
   assign slot_free_c   = !out_vld_q || m_ready;
   assign stream_next_c = ((state_q == IDLE) && start_rise_c) ||
                          ((state_q == STREAM) && start && !(xfer_c && out_q.last));

   assign in_word_c.data = rd_data;
   assign in_word_c.idx  = pend_idx_q;
   assign in_word_c.last = (pend_idx_q == ADDR_WIDTH'(OUTPUT_MAP - 1));

   assign m_valid = out_vld_q;
   assign m_data  = out_q.data;
   assign m_index = out_q.idx;
   assign m_last  = out_q.last;

   // Control FSM; busy/done registered alongside the state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         start_q <= start;
         case (state_q)
            IDLE: begin
               if (start_rise_c) begin
                  state_q <= STREAM;
                  busy    <= 1'b1;
               end
            end
            STREAM: begin
               if (!start) begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end else if (xfer_c && out_q.last) begin
                  state_q <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            DONE: begin
               if (!start) begin
                  state_q <= IDLE;
                  done    <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   // Output word register refills from the FIFO first, then from the arriving RAM word
   always_comb begin
      out_vld_n = out_vld_q;
      out_n     = out_q;
      fifo_n    = fifo_q;
      fcnt_n    = fcnt_q;
      if (slot_free_c) begin
         if (fcnt_q != 2'd0) begin
            out_vld_n = 1'b1;
            out_n     = fifo_q[0];
            fifo_n[0] = fifo_q[1];
            fcnt_n    = fcnt_q - 2'd1;
         end else if (pend_q) begin
            out_vld_n = 1'b1;
            out_n     = in_word_c;
         end else begin
            out_vld_n = 1'b0;
         end
      end
      if (pend_q && !(slot_free_c && (fcnt_q == 2'd0))) begin
         fifo_n[fcnt_n[0]] = in_word_c;
         fcnt_n            = fcnt_n + 2'd1;
      end
   end

   // Reads are decided one edge ahead from post-pop occupancy, so m_ready never reaches rd_en combinationally
   assign issue_c = stream_next_c &&
                    (next_addr_q < CNT_WIDTH'(OUTPUT_MAP)) &&
                    ((3'(fcnt_n) + 3'(rd_en)) < 3'd2);

   always_ff @(posedge clk) begin
      if (rst || !stream_next_c) begin
         out_q       <= '0;
         out_vld_q   <= 1'b0;
         fifo_q      <= '{default: '0};
         fcnt_q      <= 2'd0;
         pend_q      <= 1'b0;
         pend_idx_q  <= '0;
         next_addr_q <= '0;
         rd_en       <= 1'b0;
         rd_addr     <= '0;
      end else begin
         out_q      <= out_n;
         out_vld_q  <= out_vld_n;
         fifo_q     <= fifo_n;
         fcnt_q     <= fcnt_n;
         pend_q     <= rd_en;
         pend_idx_q <= rd_addr;
         rd_en      <= issue_c;
         if (issue_c) begin
            rd_addr     <= next_addr_q[ADDR_WIDTH-1:0];
            next_addr_q <= next_addr_q + CNT_WIDTH'(1);
         end
      end
   end

`ifdef FC_ARGMAX_EN
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // Strict greater-than keeps the lower index on ties; index 0 seeds the search
   always_ff @(posedge clk) begin
      if (rst) begin
         max_index <= '0;
         max_value <= MOST_NEG;
      end else if ((state_q == IDLE) && start_rise_c) begin
         max_index <= '0;
         max_value <= MOST_NEG;
      end else if (xfer_c && (($signed(out_q.data) > $signed(max_value)) || (out_q.idx == '0))) begin
         max_index <= out_q.idx;
         max_value <= out_q.data;
      end
   end
`else
   assign max_index = '0;
   assign max_value = '0;
`endif

endmodule

// File: tb/tb_fc_result_streamer.sv
// Directed bench for fc_result_streamer: timing, backpressure, abort, reset, restart and arg-max.
module tb_fc_result_streamer;

   localparam int unsigned DW  = 16;
   localparam int unsigned MAP = 84;
   localparam int unsigned AW  = 7;
`ifdef FC_ARGMAX_EN
   localparam bit AM = 1'b1;
`else
   localparam bit AM = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, start, rd_en, m_valid, m_ready, m_last, busy, done;
   logic [AW-1:0] rd_addr, m_index, max_index;
   logic [DW-1:0] rd_data, m_data, max_value;

   logic [DW-1:0] ram [0:127];

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] got_data [0:255];
   logic [AW-1:0] got_idx  [0:255];
   logic          got_last [0:255];
   int            got_cyc  [0:255];
   int            n_got, unstable, reads, done_cyc;

   fc_result_streamer #(.DATA_WIDTH(DW), .OUTPUT_MAP(MAP), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last),
      .busy(busy), .done(done), .max_index(max_index), .max_value(max_value)
   );

   always #5 clk = ~clk;

   // Synchronous result RAM, one cycle read latency
   always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

   // Collects transfers; mode 0 = always ready, mode 1 = random ready. Stops on done, stop_n words or budget.
   task automatic drain(input int mode, input int stop_n, input int max_cyc);
      logic          pv, pr, pl;
      logic [DW-1:0] pd;
      logic [AW-1:0] pi;
      n_got = 0; unstable = 0; reads = 0; done_cyc = -1;
      pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0; pi = '0;
      for (int cyc = 2; cyc < max_cyc; cyc++) begin
         @(negedge clk);
         if (rd_en) reads++;
         if (pv && !pr && (!m_valid || m_data !== pd || m_index !== pi || m_last !== pl)) unstable++;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (m_valid && m_ready) begin
            if (n_got < 256) begin
               got_data[n_got] = m_data;
               got_idx[n_got]  = m_index;
               got_last[n_got] = m_last;
               got_cyc[n_got]  = cyc;
            end
            n_got++;
         end
         pv = m_valid; pr = m_ready; pd = m_data; pi = m_index; pl = m_last;
         if (stop_n > 0 && n_got == stop_n) break;
      end
   endtask

   function automatic int order_errs();
      int e = 0;
      for (int i = 0; i < n_got && i < 256; i++) begin
         if (got_idx[i] !== AW'(i) || got_data[i] !== ram[i] || got_last[i] !== (i == MAP - 1)) e++;
      end
      return e;
   endfunction

   // Drops start for two cycles then raises it; returns at the negedge of cycle T+1
   task automatic kick();
      start = 1'b0; m_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      start = 1'b1;
      @(negedge clk);
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < 128; i++) ram[i] = DW'(i);
   endtask

   task automatic test_reset();
      logic [DW-1:0] exp_mv;
      exp_mv = AM ? 16'h8000 : 16'h0000;
      rst = 1'b1; start = 1'b0; m_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++; if ({rd_en, m_valid, m_last, busy, done} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {rd_en, m_valid, m_last, busy, done}); end
      total++; if ({rd_addr, m_index, max_index} !== '0) begin bad++; $display("FAIL reset_addr rd_addr=%0d m_index=%0d max_index=%0d want 0", rd_addr, m_index, max_index); end
      total++; if (m_data !== 16'h0 || max_value !== exp_mv) begin bad++; $display("FAIL reset_data m_data=%h max_value=%h want 0000/%h", m_data, max_value, exp_mv); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      fill_ramp();
      kick();
      total++; if (rd_en !== 1'b1 || rd_addr !== 7'd0) begin bad++; $display("FAIL basic_first_read rd_en=%b rd_addr=%0d want 1/0", rd_en, rd_addr); end
      drain(0, 0, 300);
      total++; if (n_got !== 84) begin bad++; $display("FAIL basic_count got=%0d want=84", n_got); end
      total++; if (order_errs() !== 0) begin bad++; $display("FAIL basic_order errs=%0d want=0", order_errs()); end
      total++; if (got_cyc[0] !== 3 || got_cyc[83] !== 86) begin bad++; $display("FAIL basic_timing first=%0d last=%0d want 3/86", got_cyc[0], got_cyc[83]); end
      total++; if (done_cyc !== 87 || busy !== 1'b0) begin bad++; $display("FAIL basic_done done_cyc=%0d busy=%b want 87/0", done_cyc, busy); end
      total++; if (reads !== 83) begin bad++; $display("FAIL basic_reads got=%0d want=83", reads); end
      total++; if (max_index !== (AM ? 7'd83 : 7'd0) || max_value !== (AM ? 16'd83 : 16'd0)) begin bad++; $display("FAIL basic_argmax idx=%0d val=%0d want %0d/%0d", max_index, max_value, AM ? 83 : 0, AM ? 83 : 0); end
   endtask

   task automatic test_hold_after_done();
      int extra_reads = 0;
      int not_done    = 0;
      repeat (10) begin
         @(negedge clk);
         if (rd_en) extra_reads++;
         if (done !== 1'b1) not_done++;
      end
      total++; if (extra_reads !== 0) begin bad++; $display("FAIL hold_reads got=%0d want=0", extra_reads); end
      total++; if (not_done !== 0) begin bad++; $display("FAIL hold_done cycles_low=%0d want=0", not_done); end
      start = 1'b0;
      @(negedge clk);
      total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL hold_exit done=%b busy=%b want 0/0", done, busy); end
   endtask

   task automatic test_back_to_back();
      kick();
      total++; if (rd_en !== 1'b1 || rd_addr !== 7'd0) begin bad++; $display("FAIL b2b_first_read rd_en=%b rd_addr=%0d want 1/0", rd_en, rd_addr); end
      drain(0, 0, 300);
      total++; if (n_got !== 84 || order_errs() !== 0) begin bad++; $display("FAIL b2b_stream count=%0d errs=%0d want 84/0", n_got, order_errs()); end
   endtask

   task automatic test_backpressure();
      fill_ramp();
      kick();
      drain(1, 0, 3000);
      total++; if (n_got !== 84) begin bad++; $display("FAIL bp_count got=%0d want=84", n_got); end
      total++; if (order_errs() !== 0) begin bad++; $display("FAIL bp_order errs=%0d want=0", order_errs()); end
      total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable changes=%0d want=0", unstable); end
      total++; if (done_cyc == -1) begin bad++; $display("FAIL bp_done timeout got=%0d want>0", done_cyc); end
      total++; if (max_index !== (AM ? 7'd83 : 7'd0)) begin bad++; $display("FAIL bp_argmax idx=%0d want=%0d", max_index, AM ? 83 : 0); end
   endtask

   task automatic test_argmax();
      for (int i = 0; i < 128; i++) ram[i] = 16'hFFFB;
      ram[10] = 16'd300; ram[40] = 16'd300;
      kick();
      drain(0, 0, 300);
      total++; if (n_got !== 84 || order_errs() !== 0) begin bad++; $display("FAIL am_stream count=%0d errs=%0d want 84/0", n_got, order_errs()); end
      total++; if (max_index !== (AM ? 7'd10 : 7'd0) || max_value !== (AM ? 16'd300 : 16'd0)) begin bad++; $display("FAIL am_tie idx=%0d val=%0d want %0d/%0d", max_index, max_value, AM ? 10 : 0, AM ? 300 : 0); end
      for (int i = 0; i < 128; i++) ram[i] = 16'h8000;
      kick();
      drain(0, 0, 300);
      total++; if (max_index !== 7'd0 || max_value !== (AM ? 16'h8000 : 16'h0000)) begin bad++; $display("FAIL am_allneg idx=%0d val=%h want 0/%h", max_index, max_value, AM ? 16'h8000 : 16'h0000); end
   endtask

   task automatic test_abort();
      fill_ramp();
      kick();
      drain(0, 20, 300);
      @(negedge clk);
      total++; if (n_got !== 20) begin bad++; $display("FAIL abort_pre count=%0d want=20", n_got); end
      start = 1'b0; m_ready = 1'b0;
      @(negedge clk);
      total++; if (m_valid !== 1'b0 || rd_en !== 1'b0) begin bad++; $display("FAIL abort_flush m_valid=%b rd_en=%b want 0/0", m_valid, rd_en); end
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_idle busy=%b done=%b want 0/0", busy, done); end
      start = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      total++; if (rd_en !== 1'b1 || rd_addr !== 7'd0) begin bad++; $display("FAIL abort_restart rd_en=%b rd_addr=%0d want 1/0", rd_en, rd_addr); end
      drain(0, 0, 300);
      total++; if (n_got !== 84 || order_errs() !== 0 || done_cyc !== 87) begin bad++; $display("FAIL abort_stream count=%0d errs=%0d done_cyc=%0d want 84/0/87", n_got, order_errs(), done_cyc); end
   endtask

   task automatic test_rst_mid();
      int            stale = 0;
      logic [DW-1:0] exp_mv;
      exp_mv = AM ? 16'h8000 : 16'h0000;
      fill_ramp();
      kick();
      m_ready = 1'b0;
      repeat (10) @(negedge clk);
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL rst_pre m_valid=%b want=1", m_valid); end
      rst = 1'b1; start = 1'b0;
      @(negedge clk);
      total++; if ({rd_en, m_valid, m_last, busy, done} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b want=00000", {rd_en, m_valid, m_last, busy, done}); end
      total++; if ({rd_addr, m_index, max_index} !== '0 || m_data !== 16'h0 || max_value !== exp_mv) begin bad++; $display("FAIL rst_values rd_addr=%0d m_index=%0d m_data=%h max_value=%h", rd_addr, m_index, m_data, max_value); end
      rst = 1'b0; m_ready = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (m_valid || rd_en) stale++;
      end
      total++; if (stale !== 0) begin bad++; $display("FAIL rst_stale cycles=%0d want=0", stale); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; m_ready = 1'b0;
      test_reset();
      test_basic();
      test_hold_after_done();
      test_back_to_back();
      test_backpressure();
      test_argmax();
      test_abort();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
